lock_code_player: RTL and testbench

- Digit-entry initiator for the combination lock FSM. It replays a code digit-by-digit into the lock's Digit/Enter inputs, then waits for the lock's Open/Fail verdict.
- Optional sweep mode: on Fail, increments the code and retries until the lock opens or the code space is exhausted.
- Sits in the board top level beside the lock. Its LockReset output is OR'd with the push-button reset into the lock's Reset; Digit/Enter are muxed with the switch/key path.

---
 rtl/lock_code_player_if.sv | 44 ++++
 rtl/lock_code_player.sv | 192 +++++++++++++++++++
 tb/tb_lock_code_player.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_code_player_if.sv
// Bundle of the signals between lock_code_player and its surroundings:
// the request side (start/sweep/code), the lock side (digit/enter/lock_reset,
// open/fail) and the status side (busy/done/success/timeout/attempt/state).
//
// Handshake semantics: start is a one-cycle request that is accepted only on
// a rising edge where busy is low; a start seen while busy is dropped, never
// queued. enter and lock_reset are one-cycle strobes toward the lock with no
// back-pressure. open/fail are level verdicts from the lock, looked at only
// while the player is waiting for a verdict. done is a one-cycle completion
// strobe; success/timeout/attempt are valid from done until the next accepted
// start.
interface lock_code_player_if #(
  parameter int NumDigits  = 4,
  parameter int DigitWidth = 4
);
  localparam int CodeWidth = NumDigits * DigitWidth;

  logic                  start;
  logic                  sweep;
  logic [CodeWidth-1:0]  code;
  logic [DigitWidth-1:0] digit;
  logic                  enter;
  logic                  lock_reset;
  logic                  open;
  logic                  fail;
  logic                  busy;
  logic                  done;
  logic                  success;
  logic                  timeout;
  logic [CodeWidth-1:0]  attempt;
  logic [2:0]            state;

  // Player side.
  modport master (
    input  start, sweep, code, open, fail,
    output digit, enter, lock_reset, busy, done, success, timeout, attempt, state
  );

  // Requester / lock side.
  modport slave (
    output start, sweep, code, open, fail,
    input  digit, enter, lock_reset, busy, done, success, timeout, attempt, state
  );
endinterface

// File: rtl/lock_code_player.sv
// Replays a code digit-by-digit into a combination lock, then waits for the
// lock's verdict. In sweep mode a failed attempt bumps the code by one and
// retries until the lock opens or the code reaches all ones.
module lock_code_player #(
  parameter int NumDigits   = 4,
  parameter int DigitWidth  = 4,
  parameter int GapCycles   = 16,
  parameter int RespTimeout = 64
) (
  input  logic               clk,
  input  logic               rst,
  lock_code_player_if.master bus
);
  localparam int CodeWidth = NumDigits * DigitWidth;
  localparam int IdxWidth  = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int GapWidth  = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam int RespWidth = (RespTimeout > 1) ? $clog2(RespTimeout) : 1;

  localparam logic [IdxWidth-1:0]  LastIdx  = IdxWidth'(NumDigits - 1);
  localparam logic [GapWidth-1:0]  GapLast  = GapWidth'(GapCycles - 1);
  localparam logic [RespWidth-1:0] RespLast = RespWidth'(RespTimeout - 1);
  localparam logic [CodeWidth-1:0] AllOnes  = {CodeWidth{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SEND   = 3'd2,
    S_GAP    = 3'd3,
    S_WAIT   = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [CodeWidth-1:0]   attempt_q, attempt_d;
  logic                   sweep_q, sweep_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [GapWidth-1:0]    gap_q, gap_d;
  logic [RespWidth-1:0]   resp_q, resp_d;
  logic                   success_q, success_d;
  logic                   timeout_q, timeout_d;

  logic [DigitWidth-1:0]  digit_sel;
  logic                   enter_o;
  logic                   lock_reset_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   show_digit;

  // Select the digit at the current index; index 0 is the most significant.
  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (idx_q == IdxWidth'(i)) begin
        digit_sel = attempt_q[(NumDigits - 1 - i) * DigitWidth +: DigitWidth];
      end
    end
  end

  // State and datapath registers; reset aborts any run with no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      attempt_q <= '0;
      sweep_q   <= 1'b0;
      idx_q     <= '0;
      gap_q     <= '0;
      resp_q    <= '0;
      success_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      attempt_q <= attempt_d;
      sweep_q   <= sweep_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      resp_q    <= resp_d;
      success_q <= success_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, counter updates and state-decoded strobes.
  always_comb begin
    state_d      = state_q;
    attempt_d    = attempt_q;
    sweep_d      = sweep_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    resp_d       = resp_q;
    success_d    = success_q;
    timeout_d    = timeout_q;
    enter_o      = 1'b0;
    lock_reset_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    show_digit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (bus.start) begin
          attempt_d = bus.code;
          sweep_d   = bus.sweep;
          success_d = 1'b0;
          timeout_d = 1'b0;
          idx_d     = '0;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        lock_reset_o = 1'b1;
        state_d      = S_SEND;
      end

      S_SEND: begin
        enter_o    = 1'b1;
        show_digit = 1'b1;
        gap_d      = '0;
        state_d    = S_GAP;
      end

      S_GAP: begin
        show_digit = 1'b1;
        if (gap_q == GapLast) begin
          gap_d = '0;
          if (idx_q == LastIdx) begin
            resp_d  = '0;
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_WAIT: begin
        // Fail wins over Open when both are high.
        if (bus.fail) begin
          if (sweep_q && (attempt_q != AllOnes)) begin
            state_d = S_NEXT;
          end else begin
            success_d = 1'b0;
            state_d   = S_FINISH;
          end
        end else if (bus.open) begin
          success_d = 1'b1;
          state_d   = S_FINISH;
        end else if (resp_q == RespLast) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          resp_d = resp_q + 1'b1;
        end
      end

      S_NEXT: begin
        // All-ones never reaches here, so the increment cannot wrap.
        attempt_d = attempt_q + 1'b1;
        idx_d     = '0;
        state_d   = S_CLEAR;
      end

      S_FINISH: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs toward the lock and status; strobes decode the state register
  // directly so they drop as soon as reset forces the state to IDLE.
  always_comb begin
    bus.digit      = show_digit ? digit_sel : '0;
    bus.enter      = enter_o;
    bus.lock_reset = lock_reset_o;
    bus.busy       = busy_o;
    bus.done       = done_o;
    bus.success    = success_q;
    bus.timeout    = timeout_q;
    bus.attempt    = attempt_q;
    bus.state      = state_q;
  end
endmodule

// File: tb/tb_lock_code_player.sv
// Bench for lock_code_player with a small behavioural lock (code 0x1234,
// verdict three cycles after the fourth Enter).
module tb_lock_code_player;
  localparam int NumDigits   = 4;
  localparam int DigitWidth  = 4;
  localparam int GapCycles   = 2;
  localparam int RespTimeout = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lock_code_player_if #(.NumDigits(NumDigits), .DigitWidth(DigitWidth)) bus ();

  lock_code_player #(
    .NumDigits  (NumDigits),
    .DigitWidth (DigitWidth),
    .GapCycles  (GapCycles),
    .RespTimeout(RespTimeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- counters and scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  int lr_count    = 0;
  int enter_count = 0;

  logic [15:0] exp_lr_q[$];     // cycle of each expected lock_reset
  logic [19:0] exp_enter_q[$];  // {cycle, digit}
  logic [33:0] exp_done_q[$];   // {cycle, success, timeout, attempt}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int at_cycle);
    vectors++;
    miscompares++;
    $display("FAIL %s: event at cycle %0d, none expected", name, at_cycle);
  endtask

  // ---------------- behavioural lock ----------------
  int          lock_mode   = 0;  // 0 normal, 1 silent, 2 open+fail together
  logic        model_open  = 1'b0;
  logic        model_fail  = 1'b0;
  logic        glitch_open = 1'b0;
  logic [15:0] entered     = '0;
  int          entered_cnt = 0;
  int          pending     = 0;

  assign bus.open = model_open | glitch_open;
  assign bus.fail = model_fail;

  always @(negedge clk) begin
    model_open = 1'b0;
    model_fail = 1'b0;
    if (rst || bus.lock_reset) begin
      entered     = '0;
      entered_cnt = 0;
      pending     = 0;
    end else begin
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          if (lock_mode == 0) begin
            if (entered == 16'h1234) model_open = 1'b1;
            else                     model_fail = 1'b1;
          end else if (lock_mode == 2) begin
            model_open = 1'b1;
            model_fail = 1'b1;
          end
        end
      end
      if (bus.enter && entered_cnt < 4) begin
        entered = {entered[11:0], bus.digit};
        entered_cnt++;
        if (entered_cnt == 4) pending = 3;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lock_reset) begin
        lr_count++;
        if (exp_lr_q.size() == 0) flag("lock_reset_unexpected", cyc);
        else check("lock_reset_cycle", 64'(cyc[15:0]), 64'(exp_lr_q.pop_front()));
      end
      if (bus.enter) begin
        enter_count++;
        if (exp_enter_q.size() == 0) flag("enter_unexpected", cyc);
        else check("enter_cycle_digit", 64'({cyc[15:0], bus.digit}), 64'(exp_enter_q.pop_front()));
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) flag("done_unexpected", cyc);
        else check("done_cycle_result",
                   64'({cyc[15:0], bus.success, bus.timeout, bus.attempt}),
                   64'(exp_done_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // c is the cycle in which start is driven; the run's attempt k begins at
  // c + 15*k (1 clear + 4*(1 enter + 2 gap) + 1 verdict cycle + 1 next).
  task automatic expect_run(input int c, input logic [15:0] first, input int attempts,
                            input logic succ, input logic tmo);
    logic [15:0] a;
    int          base;
    for (int k = 0; k < attempts; k++) begin
      a    = first + 16'(k);
      base = c + 15 * k;
      exp_lr_q.push_back(16'(base + 1));
      for (int j = 0; j < 4; j++) begin
        exp_enter_q.push_back({16'(base + 2 + 3 * j), a[(3 - j) * 4 +: 4]});
      end
    end
    base = c + 15 * (attempts - 1);
    a    = first + 16'(attempts - 1);
    exp_done_q.push_back({16'(base + (tmo ? 22 : 15)), succ, tmo, a});
  endtask

  task automatic start_run(input logic [15:0] code, input logic sweep, output int c);
    @(negedge clk);
    c         = cyc;
    bus.code  = code;
    bus.sweep = sweep;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.code  = 16'hA5C3;     // must not disturb the run in progress
    bus.sweep = ~sweep;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || exp_lr_q.size() != 0 || exp_enter_q.size() != 0 ||
                exp_done_q.size() != 0) && n < 400);
    check({name, "_completes"}, 64'(n >= 400), 64'(0));
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    bus.start = 1'b0;
    bus.sweep = 1'b0;
    bus.code  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({bus.digit, bus.enter, bus.lock_reset, bus.busy, bus.done,
               bus.success, bus.timeout, bus.attempt, bus.state}), 64'(0));
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'({bus.state, bus.busy}), 64'(0));

    // Correct code, no sweep.
    start_run(16'h1234, 1'b0, c);
    expect_run(c, 16'h1234, 1, 1'b1, 1'b0);
    wait_idle("single_open");
    check("attempt_held", 64'(bus.attempt), 64'(16'h1234));

    // Sweep from 0x1230 up to the lock's code.
    lr_count    = 0;
    enter_count = 0;
    start_run(16'h1230, 1'b1, c);
    expect_run(c, 16'h1230, 5, 1'b1, 1'b0);
    wait_idle("sweep_open");
    check("sweep_lock_reset_count", 64'(lr_count), 64'(5));
    check("sweep_enter_count", 64'(enter_count), 64'(20));

    // Sweep that hits the top of the code space.
    start_run(16'hFFFE, 1'b1, c);
    expect_run(c, 16'hFFFE, 2, 1'b0, 1'b0);
    wait_idle("sweep_exhaust");

    // Silent lock: timeout, then a new start clears it.
    lock_mode = 1;
    start_run(16'h1234, 1'b0, c);
    expect_run(c, 16'h1234, 1, 1'b0, 1'b1);
    wait_idle("timeout");
    check("timeout_held", 64'({bus.timeout, bus.success}), 64'(2'b10));
    lock_mode = 0;
    start_run(16'h1234, 1'b0, c);
    expect_run(c, 16'h1234, 1, 1'b1, 1'b0);
    check("timeout_cleared", 64'(bus.timeout), 64'(0));
    wait_idle("after_timeout");

    // Open and Fail together is a failure.
    lock_mode = 2;
    start_run(16'h1234, 1'b0, c);
    expect_run(c, 16'h1234, 1, 1'b0, 1'b0);
    wait_idle("open_and_fail");
    lock_mode = 0;

    // Open pulsed during the last GAP is ignored; wrong code fails.
    start_run(16'h1111, 1'b0, c);
    expect_run(c, 16'h1111, 1, 1'b0, 1'b0);
    wait_cycle(c + 12);
    glitch_open = 1'b1;
    wait_cycle(c + 14);
    glitch_open = 1'b0;
    wait_idle("open_in_gap");

    // Reset during GAP of digit 2 aborts with no done.
    start_run(16'h1234, 1'b0, c);
    exp_lr_q.push_back(16'(c + 1));
    exp_enter_q.push_back({16'(c + 2), 4'h1});
    exp_enter_q.push_back({16'(c + 5), 4'h2});
    wait_cycle(c + 6);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs",
          64'({bus.digit, bus.enter, bus.lock_reset, bus.busy, bus.done,
               bus.success, bus.timeout, bus.attempt, bus.state}), 64'(0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_queues_drained",
          64'(exp_lr_q.size() + exp_enter_q.size() + exp_done_q.size()), 64'(0));
    check("abort_idle", 64'({bus.state, bus.busy}), 64'(0));

    // Start while busy is dropped.
    start_run(16'h1234, 1'b0, c);
    expect_run(c, 16'h1234, 1, 1'b1, 1'b0);
    wait_cycle(c + 5);
    bus.code  = 16'h5555;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("start_while_busy");
    repeat (20) @(negedge clk);
    check("no_second_run", 64'({bus.state, bus.busy, bus.attempt}), 64'({3'd0, 1'b0, 16'h1234}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "time limit");
  end
endmodule
